// File: rtl/parity_pkg.sv
// Shared types and sizing helpers for the serial parity generator/checker pair.
package parity_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PAR} par_rx_state_t;

  // Width that holds a count of ones over DATA_W data bits plus the parity bit.
  function automatic int ones_w(input int data_w);
    return $clog2(data_w + 2);
  endfunction

endpackage

// File: rtl/par_out_buf.sv
// One-entry valid/ready register slice for checked frames; flags frames it must drop.
module par_out_buf #(
  parameter int DATA_W = 8,
  parameter int ONES_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ONES_W-1:0] in_ones,
  input  logic              in_err,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [ONES_W-1:0] m_ones,
  output logic              m_par_err,
  output logic              drop
);

  logic load;

  // A slot freed by this cycle's acceptance can be refilled immediately.
  assign load = in_valid && (!m_valid || m_ready);
  assign drop = in_valid && m_valid && !m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_ones    <= '0;
      m_par_err <= 1'b0;
    end else if (load) begin
      m_valid   <= 1'b1;
      m_data    <= in_data;
      m_ones    <= in_ones;
      m_par_err <= in_err;
    end else if (m_ready) begin
      m_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Receive-side serial parity checker: deserialises DATA_W data bits plus a parity bit,
// checks parity, counts ones and buffers the result on a valid/ready output.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  input  logic                        s_bit,
  input  logic                        s_sof,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [ones_w(DATA_W)-1:0]   m_ones,
  output logic                        m_par_err,
  output logic                        abort,
  output logic                        overrun,
  input  logic                        clr_overrun
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int ONES_W = ones_w(DATA_W);

  par_rx_state_t     state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_acc;
  logic [ONES_W-1:0] ones_acc;

  logic              start, data_bit;
  logic              abort_nxt, frame_done;
  logic              frame_err;
  logic [ONES_W-1:0] frame_ones;
  logic              drop;

  // An s_sof bit always starts a fresh frame, whatever state we are in.
  assign start    = s_valid && s_sof;
  assign data_bit = s_valid && !s_sof && (state == DATA);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    abort_nxt  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DATA;
      end
      DATA: begin
        if (start) begin
          abort_nxt = 1'b1;
        end else if (s_valid && cnt == CNT_W'(DATA_W - 1)) begin
          state_nxt = PAR;
        end
      end
      PAR: begin
        if (start) begin
          state_nxt = DATA;
          abort_nxt = 1'b1;
        end else if (s_valid) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      abort   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      abort <= abort_nxt;
      if (start)         cnt <= CNT_W'(1);
      else if (data_bit) cnt <= cnt + CNT_W'(1);
      if (clr_overrun)   overrun <= 1'b0;
      else if (drop)     overrun <= 1'b1;
    end
  end

  // Data accumulators are restarted by every s_sof, so they need no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      shreg    <= {s_bit, shreg[DATA_W-1:1]};
      par_acc  <= s_bit;
      ones_acc <= ONES_W'(s_bit);
    end else if (data_bit) begin
      shreg    <= {s_bit, shreg[DATA_W-1:1]};
      par_acc  <= par_acc ^ s_bit;
      ones_acc <= ones_acc + ONES_W'(s_bit);
    end
  end

  assign frame_ones = ones_acc + ONES_W'(s_bit);
  assign frame_err  = par_acc ^ s_bit ^ (PARITY_ODD != 0);

  par_out_buf #(
    .DATA_W (DATA_W),
    .ONES_W (ONES_W)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (frame_done),
    .in_data   (shreg),
    .in_ones   (frame_ones),
    .in_err    (frame_err),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ones    (m_ones),
    .m_par_err (m_par_err),
    .drop      (drop)
  );

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed and gap-randomised bench for parity_frame_checker (odd and even parity builds).
module tb_parity_frame_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, s_valid, s_bit, s_sof, m_ready, clr_overrun;
  logic       m_valid, m_par_err, abort, overrun;
  logic [7:0] m_data;
  logic [3:0] m_ones;
  logic       e_valid, e_par_err, e_abort, e_overrun;
  logic [7:0] e_data;
  logic [3:0] e_ones;

  int checks = 0;
  int errors = 0;

  parity_frame_checker #(.DATA_W(8), .PARITY_ODD(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ones(m_ones),
    .m_par_err(m_par_err), .abort(abort), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  parity_frame_checker #(.DATA_W(8), .PARITY_ODD(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_bit(s_bit), .s_sof(s_sof),
    .m_valid(e_valid), .m_ready(m_ready), .m_data(e_data), .m_ones(e_ones),
    .m_par_err(e_par_err), .abort(e_abort), .overrun(e_overrun), .clr_overrun(clr_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sof);
    s_valid = 1'b1; s_bit = b; s_sof = sof;
    tick();
    s_valid = 1'b0; s_bit = 1'b0; s_sof = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == 0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    send_data(d);
    send_bit(p, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_bit = 1'b0; s_sof = 1'b0;
    m_ready = 1'b0; clr_overrun = 1'b0;
    tick(); tick();
    checks++;
    if ({m_valid, m_data, m_ones, m_par_err, abort, overrun} !== 16'h0) begin
      errors++;
      $display("FAIL reset_odd: got v=%b d=%h o=%0d e=%b a=%b ov=%b, want all 0",
               m_valid, m_data, m_ones, m_par_err, abort, overrun);
    end
    checks++;
    if ({e_valid, e_data, e_ones, e_par_err, e_abort, e_overrun} !== 16'h0) begin
      errors++;
      $display("FAIL reset_even: got v=%b d=%h o=%0d e=%b a=%b ov=%b, want all 0",
               e_valid, e_data, e_ones, e_par_err, e_abort, e_overrun);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    m_ready = 1'b1;
    send_data(8'hA5);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL basic_latency: m_valid=%b before parity, want 0", m_valid);
    end
    send_bit(1'b1, 1'b0);
    checks++;
    if ({m_valid, m_data, m_ones, m_par_err} !== {1'b1, 8'hA5, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL basic_frame: got v=%b d=%h o=%0d e=%b, want v=1 d=a5 o=5 e=0",
               m_valid, m_data, m_ones, m_par_err);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL basic_accept: m_valid=%b after accept, want 0", m_valid);
    end
  endtask

  task automatic test_parity_err();
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b0);
    checks++;
    if ({m_valid, m_data, m_ones, m_par_err} !== {1'b1, 8'hA5, 4'd4, 1'b1}) begin
      errors++;
      $display("FAIL parerr_odd: got v=%b d=%h o=%0d e=%b, want v=1 d=a5 o=4 e=1",
               m_valid, m_data, m_ones, m_par_err);
    end
    checks++;
    if ({e_valid, e_data, e_ones, e_par_err} !== {1'b1, 8'hA5, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL parerr_even: got v=%b d=%h o=%0d e=%b, want v=1 d=a5 o=4 e=0",
               e_valid, e_data, e_ones, e_par_err);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] d;
    m_ready = 1'b1;
    d = 8'hC3;
    for (int i = 0; i < 4; i++) send_bit(d[i], i == 0);
    checks++;
    if (abort !== 1'b0) begin
      errors++; $display("FAIL abort_idle: abort=%b before restart, want 0", abort);
    end
    d = 8'h3C;
    send_bit(d[0], 1'b1);
    checks++;
    if (abort !== 1'b1) begin
      errors++; $display("FAIL abort_pulse: abort=%b after early sof, want 1", abort);
    end
    for (int i = 1; i < 8; i++) begin
      send_bit(d[i], 1'b0);
      if (i == 1) begin
        checks++;
        if (abort !== 1'b0) begin
          errors++; $display("FAIL abort_single: abort=%b one cycle later, want 0", abort);
        end
      end
    end
    send_bit(1'b1, 1'b0);
    checks++;
    if ({m_valid, m_data, m_ones, m_par_err} !== {1'b1, 8'h3C, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL abort_frame: got v=%b d=%h o=%0d e=%b, want v=1 d=3c o=5 e=0",
               m_valid, m_data, m_ones, m_par_err);
    end
    tick();
  endtask

  task automatic test_overrun();
    m_ready = 1'b0;
    send_frame(8'h01, 1'b0);
    checks++;
    if ({m_valid, m_data, m_ones, m_par_err, overrun} !== {1'b1, 8'h01, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ovr_first: got v=%b d=%h o=%0d e=%b ov=%b, want v=1 d=01 o=1 e=0 ov=0",
               m_valid, m_data, m_ones, m_par_err, overrun);
    end
    send_frame(8'h02, 1'b0);
    checks++;
    if ({m_valid, m_data, overrun} !== {1'b1, 8'h01, 1'b1}) begin
      errors++;
      $display("FAIL ovr_set: got v=%b d=%h ov=%b, want v=1 d=01 ov=1", m_valid, m_data, overrun);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: overrun=%b after clear, want 0", overrun);
    end
    send_data(8'h03);
    clr_overrun = 1'b1;
    send_bit(1'b0, 1'b0);
    clr_overrun = 1'b0;
    checks++;
    if ({m_data, overrun} !== {8'h01, 1'b0}) begin
      errors++;
      $display("FAIL ovr_clr_priority: got d=%h ov=%b, want d=01 ov=0", m_data, overrun);
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_drain: m_valid=%b after accept, want 0", m_valid);
    end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b0;
    send_frame(8'h55, 1'b1);
    send_data(8'h0F);
    checks++;
    if ({m_valid, m_data, m_ones} !== {1'b1, 8'h55, 4'd5}) begin
      errors++;
      $display("FAIL b2b_hold: got v=%b d=%h o=%0d, want v=1 d=55 o=5", m_valid, m_data, m_ones);
    end
    m_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    checks++;
    if ({m_valid, m_data, m_ones, m_par_err, overrun} !== {1'b1, 8'h0F, 4'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_load: got v=%b d=%h o=%0d e=%b ov=%b, want v=1 d=0f o=5 e=0 ov=0",
               m_valid, m_data, m_ones, m_par_err, overrun);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: m_valid=%b, want 0", m_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    m_ready = 1'b0;
    send_frame(8'h81, 1'b1);
    d = 8'hAA;
    for (int i = 0; i < 6; i++) send_bit(d[i], i == 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({m_valid, m_data, m_ones, m_par_err, abort, overrun} !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got v=%b d=%h o=%0d e=%b a=%b ov=%b, want all 0",
               m_valid, m_data, m_ones, m_par_err, abort, overrun);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_discard: m_valid=%b from stray bits, want 0", m_valid);
    end
    m_ready = 1'b1;
    send_frame(8'hFF, 1'b1);
    checks++;
    if ({m_valid, m_data, m_ones, m_par_err} !== {1'b1, 8'hFF, 4'd9, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_ff: got v=%b d=%h o=%0d e=%b, want v=1 d=ff o=9 e=0",
               m_valid, m_data, m_ones, m_par_err);
    end
    tick();
  endtask

  task automatic test_random_gaps();
    logic [7:0] d;
    logic       p;
    logic [3:0] exp_ones;
    logic       exp_err;
    m_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      exp_ones = 4'($countones(d)) + 4'(p);
      exp_err  = ~(^{p, d});
      for (int i = 0; i < 9; i++) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0; s_sof = 1'($urandom); s_bit = 1'($urandom);
          tick();
        end
        if (i < 8) send_bit(d[i], i == 0);
        else       send_bit(p, 1'b0);
      end
      checks++;
      if ({m_valid, m_data, m_ones, m_par_err} !== {1'b1, d, exp_ones, exp_err}) begin
        errors++;
        $display("FAIL random_frame%0d: got v=%b d=%h o=%0d e=%b, want v=1 d=%h o=%0d e=%b",
                 f, m_valid, m_data, m_ones, m_par_err, d, exp_ones, exp_err);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_abort();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
